// File: rtl/register_read_arbiter.sv
// register_read_arbiter: round-robin sharing of the register file's single
// internal read port between NUM_CLIENTS requesters in the axis_aclk domain.
// Optional build macro REG_ARB_RANGE_CHECK_EN: when defined, latched
// addresses >= ENTRIES are not read and the response carries rsp_err=1.
`timescale 1ns/1ps
module register_read_arbiter #(
    parameter int NUM_CLIENTS = 2,
    parameter int ENTRIES     = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_W      = $clog2(ENTRIES)
) (
    input  logic                          axis_aclk,
    input  logic                          mod_rstn,
    input  logic [NUM_CLIENTS-1:0]        req_valid,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
    output logic [NUM_CLIENTS-1:0]        req_ready,
    output logic [NUM_CLIENTS-1:0]        rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          internal_read,
    output logic [ADDR_W-1:0]             internal_reg_addr,
    input  logic [DATA_WIDTH-1:0]         internal_reg_out
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  win_idx_p0;
    logic [ADDR_W-1:0] win_addr_p0;
    logic [IDX_W-1:0]  pick_idx;
    logic [ADDR_W-1:0] pick_addr;
    logic              pick_found;
    logic [IDX_W-1:0]  rr_cand;
    int                rr_sum;
    logic              addr_ok;

    // Round-robin search starting one past the last granted client
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        rr_sum     = 0;
        rr_cand    = '0;
        for (int off = 1; off <= NUM_CLIENTS; off++) begin
            rr_sum = int'(last_grant) + off;
            if (rr_sum >= NUM_CLIENTS) begin
                rr_sum = rr_sum - NUM_CLIENTS;
            end
            rr_cand = IDX_W'(rr_sum);
            if (!pick_found && req_valid[rr_cand]) begin
                pick_found = 1'b1;
                pick_idx   = rr_cand;
            end
        end
    end

    // Select the winning client's address slice
    always_comb begin
        pick_addr = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

`ifdef REG_ARB_RANGE_CHECK_EN
    assign addr_ok = (int'(win_addr_p0) < ENTRIES);
`else
    assign addr_ok = 1'b1;
`endif

    // FSM state register
    always_ff @(posedge axis_aclk or negedge mod_rstn) begin
        if (!mod_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: one READ per accepted request, then back to arbitration
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_found) state_next = READ;
            READ:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read-port and accept outputs are only active during READ
    always_comb begin
        req_ready         = '0;
        internal_read     = 1'b0;
        internal_reg_addr = '0;
        if (state == READ) begin
            internal_read     = addr_ok;
            internal_reg_addr = win_addr_p0;
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                req_ready[i] = (win_idx_p0 == IDX_W'(i));
            end
        end
    end

    // Latch the winner in IDLE and remember it as last grant after READ
    always_ff @(posedge axis_aclk or negedge mod_rstn) begin
        if (!mod_rstn) begin
            win_idx_p0 <= '0;
            last_grant <= IDX_W'(NUM_CLIENTS - 1);
        end else begin
            if (state == IDLE && pick_found) begin
                win_idx_p0 <= pick_idx;
            end
            if (state == READ) begin
                last_grant <= win_idx_p0;
            end
        end
    end

    // Latch the winner's address so later address changes cannot affect READ
    always_ff @(posedge axis_aclk) begin
        if (state == IDLE && pick_found) begin
            win_addr_p0 <= pick_addr;
        end
    end

    // Response stage: capture read data at the end of READ, pulse valid next cycle
    always_ff @(posedge axis_aclk or negedge mod_rstn) begin
        if (!mod_rstn) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= req_ready;
            if (state == READ) begin
                rsp_data <= addr_ok ? internal_reg_out : '0;
                rsp_err  <= !addr_ok;
            end
        end
    end

endmodule

// File: tb/tb_register_read_arbiter.sv
// Testbench for register_read_arbiter: directed scenarios plus a randomized
// run scored against a round-robin/register-file reference model.
`timescale 1ns/1ps
module tb_register_read_arbiter;

    localparam int N        = 2;
    localparam int ENTRIES  = 12;
    localparam int DW       = 32;
    localparam int AW       = $clog2(ENTRIES);
    localparam int WAIT_LIM = 2 * N + 1;
`ifdef REG_ARB_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic            axis_aclk = 1'b0;
    logic            mod_rstn  = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            internal_read;
    logic [AW-1:0]   internal_reg_addr;
    logic [DW-1:0]   internal_reg_out;

    // register file model with write-through on the read port
    logic [DW-1:0]   mem [ENTRIES];
    logic            wr_en   = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [DW-1:0]   wr_data = '0;
    logic [DW-1:0]   init_val [ENTRIES];

    typedef struct {
        int            cl;
        logic [DW-1:0] data;
        logic          err;
        int            due;
    } rsp_t;

    rsp_t            rq[$];
    logic [N-1:0]    snap_valid = '0;
    logic [N*AW-1:0] snap_addr  = '0;
    int              model_last;
    int              wait_cnt [N];
    int              n_chk  = 0;
    int              n_pass = 0;

    register_read_arbiter #(
        .NUM_CLIENTS(N),
        .ENTRIES    (ENTRIES),
        .DATA_WIDTH (DW)
    ) dut (
        .axis_aclk        (axis_aclk),
        .mod_rstn         (mod_rstn),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .rsp_err          (rsp_err),
        .internal_read    (internal_read),
        .internal_reg_addr(internal_reg_addr),
        .internal_reg_out (internal_reg_out)
    );

    always #5 axis_aclk = ~axis_aclk;

    function automatic bit in_range(input logic [AW-1:0] a);
        return int'(a) < ENTRIES;
    endfunction

    function automatic logic [DW-1:0] oob(input logic [AW-1:0] a);
        return 32'hBAD0_0000 | DW'(a);
    endfunction

    always_comb begin
        internal_reg_out = oob(internal_reg_addr);
        if (in_range(internal_reg_addr)) internal_reg_out = mem[internal_reg_addr];
        if (wr_en && wr_addr == internal_reg_addr) internal_reg_out = wr_data;
    end

    always @(posedge axis_aclk) begin
        if (wr_en && in_range(wr_addr)) mem[wr_addr] <= wr_data;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // first requesting client after 'last' in circular order, -1 if none
    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        logic [N-1:0] sh;
        int c;
        for (int k = 1; k <= N; k++) begin
            c  = (last + k) % N;
            sh = v >> c;
            if (sh[0]) return c;
        end
        return -1;
    endfunction

    task automatic do_reset();
        req_valid = '0;
        mod_rstn  = 1'b0;
        repeat (2) @(negedge axis_aclk);
        mod_rstn = 1'b1;
    endtask

    task automatic set_addr(input int c, input logic [AW-1:0] a);
        req_addr[c*AW +: AW] = a;
    endtask

    task automatic rand_step(input int it, input bit allow_new);
        int              w;
        logic [N-1:0]    oh;
        logic [AW-1:0]   a;
        logic [DW-1:0]   d;
        logic [N*AW-1:0] t;
        rsp_t            r;
        @(negedge axis_aclk);
        wr_en   = ($urandom_range(0, 2) == 0);
        wr_addr = AW'($urandom_range(0, ENTRIES - 1));
        wr_data = $urandom;
        if (rq.size() > 0 && rq[0].due == it) begin
            r  = rq.pop_front();
            oh = N'(1) << r.cl;
            chk("rsp_valid", 64'(rsp_valid), 64'(oh));
            chk("rsp_data", 64'(rsp_data), 64'(r.data));
            chk("rsp_err", 64'(rsp_err), 64'(r.err));
        end else begin
            chk("rsp_quiet", 64'(rsp_valid), 64'(0));
        end
        if (req_ready != '0) begin
            w = rr_pick(snap_valid, model_last);
            if (w < 0) begin
                chk("spurious_grant", 64'(req_ready), 64'(0));
            end else begin
                oh = N'(1) << w;
                chk("rr_grant", 64'(req_ready), 64'(oh));
                t = snap_addr >> (w * AW);
                a = t[AW-1:0];
                chk("rd_addr", 64'(internal_reg_addr), 64'(a));
                chk("rd_strobe", 64'(internal_read), (RC && !in_range(a)) ? 64'(0) : 64'(1));
                if (RC && !in_range(a))          d = '0;
                else if (wr_en && wr_addr == a)  d = wr_data;
                else if (in_range(a))            d = mem[a];
                else                             d = oob(a);
                r.cl   = w;
                r.data = d;
                r.err  = RC && !in_range(a);
                r.due  = it + 1;
                rq.push_back(r);
                model_last = w;
            end
        end else begin
            chk("idle_port", 64'({internal_read, internal_reg_addr}), 64'(0));
        end
        for (int c = 0; c < N; c++) begin
            if (req_ready[c]) begin
                wait_cnt[c]  = 0;
                req_valid[c] = allow_new && ($urandom_range(0, 1) == 1);
                set_addr(c, AW'($urandom_range(0, 15)));
            end else begin
                if (snap_valid[c]) begin
                    wait_cnt[c]++;
                    if (wait_cnt[c] > WAIT_LIM) begin
                        chk("starve", 64'(wait_cnt[c]), 64'(WAIT_LIM));
                        wait_cnt[c] = 0;
                    end
                end
                if (!req_valid[c] && allow_new && $urandom_range(0, 2) == 0) begin
                    req_valid[c] = 1'b1;
                    set_addr(c, AW'($urandom_range(0, 15)));
                end
            end
        end
        snap_valid = req_valid;
        snap_addr  = req_addr;
    endtask

    logic [1:0] t2_rdy [5];
    logic [1:0] t2_rsp [5];
    int         gq[$];

    initial begin
        t2_rdy = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
        t2_rsp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        for (int i = 0; i < ENTRIES; i++) init_val[i] = $urandom;
        init_val[3] = 32'hDEADBEEF;
        init_val[7] = 32'h1234_5678;
        // load the register file while held in reset
        for (int i = 0; i < ENTRIES; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = init_val[i];
            @(negedge axis_aclk);
        end
        wr_en = 1'b0;
        do_reset();

        // reset state
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_data", 64'(rsp_data), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(0));
        chk("rst_rd", 64'(internal_read), 64'(0));
        chk("rst_rd_addr", 64'(internal_reg_addr), 64'(0));

        // single read of address 3 by client 0
        req_valid = 2'b01;
        set_addr(0, AW'(3));
        @(negedge axis_aclk);
        chk("t1_ready", 64'(req_ready), 64'(2'b01));
        chk("t1_rd", 64'(internal_read), 64'(1));
        chk("t1_rd_addr", 64'(internal_reg_addr), 64'(3));
        chk("t1_no_rsp_yet", 64'(rsp_valid), 64'(0));
        req_valid = '0;
        @(negedge axis_aclk);
        chk("t1_rsp_valid", 64'(rsp_valid), 64'(2'b01));
        chk("t1_rsp_data", 64'(rsp_data), 64'(32'hDEADBEEF));
        chk("t1_rsp_err", 64'(rsp_err), 64'(0));
        chk("t1_ready_gone", 64'(req_ready), 64'(0));

        // simultaneous requests after reset: client 0 first, client 1 two cycles later
        do_reset();
        req_valid = 2'b11;
        set_addr(0, AW'(1));
        set_addr(1, AW'(2));
        for (int i = 0; i < 5; i++) begin
            @(negedge axis_aclk);
            chk($sformatf("t2_ready%0d", i), 64'(req_ready), 64'(t2_rdy[i]));
            chk($sformatf("t2_rsp%0d", i), 64'(rsp_valid), 64'(t2_rsp[i]));
            if (i == 1) chk("t2_data0", 64'(rsp_data), 64'(init_val[1]));
            if (i == 3) chk("t2_data1", 64'(rsp_data), 64'(init_val[2]));
            req_valid = req_valid & ~req_ready;
        end

        // continuous requests from both clients alternate grants
        do_reset();
        req_valid = 2'b11;
        gq.delete();
        for (int i = 0; i < 40 && gq.size() < 8; i++) begin
            @(negedge axis_aclk);
            if (req_ready != '0) gq.push_back(req_ready[1] ? 1 : 0);
        end
        req_valid = '0;
        chk("t3_grant_count", 64'(gq.size()), 64'(8));
        for (int i = 0; i < gq.size(); i++) chk($sformatf("t3_grant%0d", i), 64'(gq[i]), 64'(i % 2));
        repeat (2) @(negedge axis_aclk);

        // write-through during the READ cycle of address 7
        req_valid = 2'b01;
        set_addr(0, AW'(7));
        @(negedge axis_aclk);
        chk("t4_ready", 64'(req_ready), 64'(2'b01));
        req_valid = '0;
        wr_en     = 1'b1;
        wr_addr   = AW'(7);
        wr_data   = 32'h5;
        @(negedge axis_aclk);
        wr_en = 1'b0;
        chk("t4_rsp_valid", 64'(rsp_valid), 64'(2'b01));
        chk("t4_rsp_data", 64'(rsp_data), 64'(32'h5));

        // reset asserted in the READ cycle aborts the read
        @(negedge axis_aclk);
        req_valid = 2'b10;
        set_addr(1, AW'(4));
        @(negedge axis_aclk);
        chk("t5_ready", 64'(req_ready), 64'(2'b10));
        mod_rstn  = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge axis_aclk);
            chk($sformatf("t5_no_rsp%0d", i), 64'(rsp_valid), 64'(0));
        end
        mod_rstn = 1'b1;
        chk("t5_out_zero", 64'({req_ready, rsp_valid, rsp_data, rsp_err, internal_read, internal_reg_addr}), 64'(0));
        req_valid = 2'b11;
        set_addr(0, AW'(5));
        set_addr(1, AW'(6));
        @(negedge axis_aclk);
        chk("t5_first_grant", 64'(req_ready), 64'(2'b01));
        req_valid = '0;
        @(negedge axis_aclk);
        chk("t5_rsp_data", 64'(rsp_data), 64'(init_val[5]));

        // out-of-range address from client 1
        req_valid = 2'b10;
        set_addr(1, AW'(13));
        @(negedge axis_aclk);
        chk("t6_ready", 64'(req_ready), 64'(2'b10));
        chk("t6_rd", 64'(internal_read), RC ? 64'(0) : 64'(1));
        req_valid = '0;
        @(negedge axis_aclk);
        chk("t6_rsp_valid", 64'(rsp_valid), 64'(2'b10));
        chk("t6_rsp_data", 64'(rsp_data), RC ? 64'(0) : 64'(oob(AW'(13))));
        chk("t6_rsp_err", 64'(rsp_err), RC ? 64'(1) : 64'(0));

        // randomized traffic against the reference model
        do_reset();
        model_last = N - 1;
        snap_valid = '0;
        snap_addr  = req_addr;
        for (int c = 0; c < N; c++) wait_cnt[c] = 0;
        rq.delete();
        for (int it = 0; it < 600; it++) rand_step(it, 1'b1);
        for (int it = 600; it < 610; it++) rand_step(it, 1'b0);
        wr_en = 1'b0;
        chk("drain_empty", 64'(rq.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/register_read_arbiter.md
# register_read_arbiter

Round-robin arbiter that shares the register file's single internal read port between `NUM_CLIENTS` datapath requesters (e.g. the two CMAC-side p2p pipelines). It sits in the p2p plugin between the register file and its consumers in the `axis_aclk` domain. It accepts one read per grant, drives the register file's internal read strobe and address, and returns the registered read data to the granted client with a one-cycle valid pulse.

## Interface
Parameters:
- `NUM_CLIENTS`, 2: number of requesters. Legal range is 2..8.
- `ENTRIES`, 12: register file depth. Must match the register file.
- `DATA_WIDTH`, 32: register width.
- `ADDR_W`, `$clog2(ENTRIES)`: derived address width. Do not override.

Ports:
- `axis_aclk`, in, 1: clock.
- `mod_rstn`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, `NUM_CLIENTS`: per-client read request. Bit i belongs to client i.
- `req_addr`, in, `NUM_CLIENTS*ADDR_W`: per-client address. Client i uses slice `[i*ADDR_W +: ADDR_W]`.
- `req_ready`, out, `NUM_CLIENTS`: one-hot, one-cycle accept pulse.
- `rsp_valid`, out, `NUM_CLIENTS`: one-hot, one-cycle response pulse.
- `rsp_data`, out, `DATA_WIDTH`: response data, shared by all clients. Valid only while any `rsp_valid` bit is set.
- `rsp_err`, out, 1: out-of-range address flag. Qualified by `rsp_valid`.
- `internal_read`, out, 1: read strobe to the register file.
- `internal_reg_addr`, out, `ADDR_W`: read address to the register file.
- `internal_reg_out`, in, `DATA_WIDTH`: combinational read data from the register file.

## Operation
- FSM states: `IDLE` and `READ`.
- IDLE:
  - If any `req_valid` bit is set, select the winner round-robin. Search starts at `last_grant+1` modulo `NUM_CLIENTS`.
  - Register the winner index and its address, then go to READ.
  - If no request is pending, stay in IDLE.
- READ:
  - Assert `internal_read=1` and drive `internal_reg_addr` from the latched address.
  - Pulse `req_ready[winner]`.
  - Capture `internal_reg_out` into the `rsp_data` register.
  - Update `last_grant` to the winner and return to IDLE.
- Response: on the cycle after READ, `rsp_valid[winner]` is 1 for exactly one cycle.
- Client rules:
  - Hold `req_valid` and `req_addr` stable until `req_ready` pulses.
  - Drop `req_valid` (or present the next request) in the cycle after `req_ready`.
  - A request withdrawn before grant is a protocol violation. Its behaviour is undefined.
- Address change between arbitration and READ has no effect, because the address is latched in IDLE.
- Outside READ: `internal_read=0` and `internal_reg_addr=0`.
- Reset values:
  - Outputs: `req_ready=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_err=0`, `internal_read=0`, `internal_reg_addr=0`.
  - Internal state: FSM in IDLE, `last_grant=NUM_CLIENTS-1`, so client 0 wins first.
- Reset mid-operation: asserting `mod_rstn` low at any point aborts the transaction immediately. No `rsp_valid` is produced for the aborted read.

## Timing
- Cycle n (IDLE, request seen) leads to cycle n+1 (READ, `req_ready` pulse, register file read) and then cycle n+2 (`rsp_valid`).
- Latency from request to response is 2 cycles.
- Peak throughput is one read every 2 cycles.
- The `rsp_valid` cycle overlaps the next IDLE arbitration. Back-to-back grants are therefore possible.
- Simultaneous requests: exactly one winner per IDLE cycle. Losers keep `req_valid` high and are served in rotation, so no client waits more than `NUM_CLIENTS` grants.
- Register file writes in the same cycle as READ: `rsp_data` returns whatever `internal_reg_out` presents in that cycle. This is the register file's write-through value.

## Configuration
- Macro: `REG_ARB_RANGE_CHECK_EN`.
- Defined:
  - A latched address `>= ENTRIES` still completes READ and pulses `req_ready`.
  - `internal_read` stays 0 for that read.
  - The response carries `rsp_data=0` and `rsp_err=1`.
- Undefined:
  - `rsp_err` is tied to 0.
  - Every address is forwarded unmodified with `internal_read=1`.
  - Data for out-of-range addresses is whatever the register file returns.

## Test plan
- Reset, then client 0 reads address 3 holding `32'hDEADBEEF` -> `req_ready[0]` at +1 cycle, `rsp_valid[0]` at +2 cycles with `rsp_data=32'hDEADBEEF` and `rsp_err=0`.
- Both clients request from the same cycle (addresses 1 and 2) -> client 0 is granted first and client 1 two cycles later. Responses are one-hot and separated by 2 cycles.
- Both clients hold requests continuously for 8 grants -> grants alternate 0,1,0,1,... with no client granted twice in a row.
- A system-side write of `32'h5` to address 7 in the READ cycle of a read of address 7 -> `rsp_data=32'h5`.
- `mod_rstn` driven low in the READ cycle -> no `rsp_valid` pulse. After reset release, all outputs are 0 and the next simultaneous request grants client 0.
- With `REG_ARB_RANGE_CHECK_EN`, client 1 reads address 13 -> `req_ready[1]` pulses, `internal_read` stays 0, and the response has `rsp_data=0` and `rsp_err=1`.
